// File: rtl/serial_paralelo_param.sv
// ---------------------------------------------------------------------------
// serial_paralelo_param
// Serial-to-parallel receiver with comma-based word alignment.
// A WIDTH-bit shift register captures data_in (MSB first) every cycle. While
// searching, every post-shift word is compared against COMMA. The first match
// fixes the word boundary. LOCK_COUNT consecutive aligned commas declare lock.
// While locked, non-comma words are presented on data_output with valid_out.
// MAX_GAP consecutive non-comma words drop the lock.
//
// Ports
//   clk_32f       in   1            bit clock, rising edge
//   reset         in   1            asynchronous, active-high
//   data_in       in   1            serial data, MSB first
//   data_output   out  WIDTH        last received non-comma word
//   valid_out     out  1            data_output holds a valid non-comma word
//   word_strobe   out  1            one-cycle pulse at each word boundary
//   active_output out  1            link locked
//   BC_counter    out  BCW          consecutive aligned commas (saturating)
// ---------------------------------------------------------------------------
module serial_paralelo_param #(
   parameter int unsigned       WIDTH      = 8,
   parameter logic [WIDTH-1:0]  COMMA      = WIDTH'(8'hBC),
   parameter int unsigned       LOCK_COUNT = 4,
   parameter int unsigned       MAX_GAP    = 16,
   localparam int unsigned      BCW        = $clog2(LOCK_COUNT + 1)
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_output,
   output logic             valid_out,
   output logic             word_strobe,
   output logic             active_output,
   output logic [BCW-1:0]   BC_counter
);

   // Bit-phase / received-bit counter width; at least one bit.
   localparam int unsigned PW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   // Gap counter holds 0..MAX_GAP without wrapping.
   localparam int unsigned GW  = $clog2(MAX_GAP + 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      COUNT  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] shift_q,  shift_d;
   logic [PW-1:0]    nbits_q,  nbits_d;
   logic [PW-1:0]    phase_q,  phase_d;
   logic [GW-1:0]    gap_q,    gap_d;
   logic [WIDTH-1:0] data_q,   data_d;
   logic             valid_q,  valid_d;
   logic             strobe_q, strobe_d;
   logic             active_q, active_d;
   logic [BCW-1:0]   bc_q,     bc_d;

   logic             is_comma;
   logic             boundary;
   logic             full;
   logic             lock_reached;
   logic             gap_reached;

   // State register and all registered outputs.
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state_q  <= SEARCH;
         shift_q  <= '0;
         nbits_q  <= '0;
         phase_q  <= '0;
         gap_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
         active_q <= 1'b0;
         bc_q     <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         nbits_q  <= nbits_d;
         phase_q  <= phase_d;
         gap_q    <= gap_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         strobe_q <= strobe_d;
         active_q <= active_d;
         bc_q     <= bc_d;
      end
   end

   // Decisions are taken on the word as it will look after this edge's shift.
   always_comb begin
      shift_d      = {shift_q[WIDTH-2:0], data_in};
      is_comma     = (shift_d == COMMA);
      // nbits_q saturates at WIDTH-1: this edge brings in the WIDTH-th bit.
      full         = (nbits_q == PW'(WIDTH - 1));
      boundary     = (phase_q == PW'(WIDTH - 1));
      lock_reached = ((BCW+1)'(bc_q) + (BCW+1)'(1)) >= (BCW+1)'(LOCK_COUNT);
      gap_reached  = ((GW+1)'(gap_q) + (GW+1)'(1)) >= (GW+1)'(MAX_GAP);
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      nbits_d  = full ? nbits_q : nbits_q + PW'(1);
      phase_d  = boundary ? '0 : phase_q + PW'(1);
      gap_d    = gap_q;
      data_d   = data_q;
      valid_d  = valid_q;
      strobe_d = 1'b0;
      active_d = active_q;
      bc_d     = bc_q;

      unique case (state_q)
         SEARCH: begin
            if (full && is_comma) begin
               phase_d  = '0;
               bc_d     = BCW'(1);
               strobe_d = 1'b1;
               state_d  = COUNT;
            end
         end

         COUNT: begin
            if (boundary) begin
               strobe_d = 1'b1;
               if (is_comma) begin
                  if (lock_reached) begin
                     bc_d     = BCW'(LOCK_COUNT);
                     active_d = 1'b1;
                     state_d  = ACTIVE;
                  end else begin
                     bc_d = bc_q + BCW'(1);
                  end
               end else begin
                  bc_d    = '0;
                  state_d = SEARCH;
               end
            end
         end

         ACTIVE: begin
            if (boundary) begin
               strobe_d = 1'b1;
               if (is_comma) begin
                  valid_d = 1'b0;
                  gap_d   = '0;
                  bc_d    = BCW'(LOCK_COUNT);
               end else if (gap_reached) begin
                  // Lock lost: the gap-ending word is discarded.
                  state_d  = SEARCH;
                  active_d = 1'b0;
                  valid_d  = 1'b0;
                  bc_d     = '0;
                  gap_d    = '0;
               end else begin
                  data_d  = shift_d;
                  valid_d = 1'b1;
                  gap_d   = gap_q + GW'(1);
               end
            end
         end

         default: begin
            state_d  = SEARCH;
            active_d = 1'b0;
            valid_d  = 1'b0;
            bc_d     = '0;
            gap_d    = '0;
         end
      endcase
   end

   assign data_output   = data_q;
   assign valid_out     = valid_q;
   assign word_strobe   = strobe_q;
   assign active_output = active_q;
   assign BC_counter    = bc_q;

endmodule

// File: doc/serial_paralelo_param.md
SERIAL_PARALELO_PARAM -- requirements
Module: serial_paralelo_param

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, word width in bits.
REQ-002 Parameter COMMA SHALL default to 8'hBC and is the alignment word, WIDTH bits wide.
REQ-003 Parameter LOCK_COUNT SHALL default to 4 and is the number of consecutive aligned commas required for lock.
REQ-004 Parameter MAX_GAP SHALL default to 16 and is the number of consecutive non-comma words after which lock is dropped.
REQ-005 Ports SHALL be, in order:
- clk_32f  input  1  bit clock
- reset  input  1  asynchronous, active-high
- data_in  input  1  serial data, MSB first
- data_output  output  WIDTH  last received data word
- valid_out  output  1  data_output holds a valid non-comma word
- word_strobe  output  1  one-cycle pulse at each word boundary
- active_output  output  1  link locked
- BC_counter  output  $clog2(LOCK_COUNT+1)  count of consecutive aligned commas
REQ-006 The block SHALL use one clock, clk_32f; reset SHALL be asynchronous and active-high; all state SHALL update on the rising edge of clk_32f.

Function
REQ-007 A WIDTH-bit shift register SHALL load data_in into the LSB every cycle; the "word" is the post-shift register value.
REQ-008 The FSM SHALL have exactly three states: SEARCH, COUNT and ACTIVE.
REQ-009 In SEARCH, the block SHALL compare the word to COMMA every cycle, once at least WIDTH bits have been received since reset.
REQ-010 On a SEARCH match, the block SHALL: zero the bit-phase counter, set BC_counter=1, pulse word_strobe, and move to COUNT.
REQ-011 Word boundaries SHALL then fall every WIDTH cycles after the matching cycle; the bit-phase counter SHALL wrap from WIDTH-1 to 0.
REQ-012 In COUNT, at each boundary, a comma SHALL increment BC_counter; on reaching LOCK_COUNT the block SHALL go to ACTIVE and set active_output=1 on that same edge.
REQ-013 In COUNT, a non-comma word at a boundary SHALL clear BC_counter to 0 and return the FSM to SEARCH.
REQ-014 In COUNT, comparisons between boundaries SHALL be ignored.
REQ-015 In ACTIVE, a non-comma word at a boundary SHALL: load data_output, set valid_out=1, and increment the gap counter.
REQ-016 In ACTIVE, a comma at a boundary SHALL: clear valid_out, hold data_output, and clear the gap counter.
REQ-017 In ACTIVE, BC_counter SHALL saturate at LOCK_COUNT.
REQ-018 valid_out and data_output SHALL hold their values between boundaries, i.e. for WIDTH cycles.
REQ-019 In ACTIVE, when the gap counter reaches MAX_GAP, the block SHALL on that edge go to SEARCH, clear active_output, valid_out and BC_counter, and not load the word.
REQ-020 word_strobe SHALL pulse for exactly one cycle at every boundary in COUNT and ACTIVE, and SHALL never pulse in SEARCH except on the matching cycle.
REQ-021 A comma that straddles a boundary in COUNT or ACTIVE SHALL NOT cause realignment; realignment SHALL occur only through SEARCH.
REQ-022 The gap counter SHALL be $clog2(MAX_GAP+1) bits wide and SHALL never wrap.

Reset
REQ-023 While reset=1, the block SHALL force: state=SEARCH, shift register=0, bit count=0, gap=0, data_output=0, valid_out=0, word_strobe=0, active_output=0, BC_counter=0.
REQ-024 Reset asserted mid-word or while ACTIVE SHALL take effect immediately, without waiting for a clock edge.
REQ-025 After reset deasserts, the block SHALL restart bit counting from zero.

Verification (WIDTH=8, COMMA=BC, LOCK_COUNT=4, MAX_GAP=16)
REQ-026 Test 1: four BC words, then 0x55 -> BC_counter steps 1,2,3,4; active_output rises at the 4th boundary; at the next boundary data_output=0x55 and valid_out=1.
REQ-027 Test 2: 3 leading junk bits, then BC x4 -> alignment occurs on the BC ending 11 cycles after reset release; lock is achieved and data is aligned.
REQ-028 Test 3: BC,BC,0x00,BC... -> BC_counter goes 1,2,0, the FSM returns to SEARCH, and active_output stays 0.
REQ-029 Test 4: lock, then data 0xA1,BC,0xA2 -> valid_out goes 1, 0, 1 across the boundaries; data_output is 0xA1, 0xA1, 0xA2.
REQ-030 Test 5: lock, then 16 non-comma words -> on the 16th boundary active_output=0, valid_out=0, BC_counter=0; data_output retains the 15th word.
REQ-031 Test 6: reset pulse while ACTIVE, mid-word -> all outputs are 0 immediately; four fresh BC words are needed to relock.
